// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the dm_wb data memory slave
// Purpose: FSM state encoding, wait-counter width and byte-lane count helper.
// Ports: none (package).
package dm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Wide enough for WAIT_CYC-1 with WAIT_CYC up to 15.
    localparam int WCNT_W = 4;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - single-port data array with per-byte write enables
// Purpose: storage behind dm_wb; synchronous byte-masked write, read port
//          presents the addressed word so the caller can register it.
// Ports: clk, we (write strobe), be (byte enables), addr (word address),
//        wdata (write data), rdata (word at addr). No reset: contents persist.
module dm_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_wb.sv
// rtl/dm_wb.sv - data-bus memory slave with wait states, byte enables and range error
// Purpose: accepts dbus requests (cyc & stb) in IDLE, optionally waits WAIT_CYC
//          cycles, then performs one read/write/error access and pulses done or err.
// Ports: clk, rst_n (async active-low), addr/wr/sel/wdata (request),
//        dbus_cyc_o/dbus_stb_o (qualifiers), rdata (registered read data),
//        done/err (single-cycle completion pulses).
module dm_wb
    import dm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 128,
    parameter int WAIT_CYC = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  wr,
    input  logic                  dbus_cyc_o,
    input  logic                  dbus_stb_o,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  done,
    output logic                  err
);

    localparam int NB = lanes(DATA_W);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [NB-1:0]       sel_q, sel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                req;
    logic                access;
    logic                in_range;
    logic                ram_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic                acc_wr;
    logic [NB-1:0]       acc_sel;
    logic [DATA_W-1:0]   acc_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    // The cycle showing done/err is a forced turnaround, so requests are masked then.
    assign req = dbus_cyc_o & dbus_stb_o & ~done_q & ~err_q;

    // A zero-wait access happens on the accepting edge, so it must use the live
    // request; a delayed access uses the captured copy.
    always_comb begin
        acc_addr  = addr_q;
        acc_wr    = wr_q;
        acc_sel   = sel_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_addr  = addr;
            acc_wr    = wr;
            acc_sel   = sel;
            acc_wdata = wdata;
        end
    end

    assign in_range = {1'b0, acc_addr} < (ADDR_W + 1)'(DEPTH);
    assign ram_we   = access & acc_wr & in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        access  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wr_d    = wr;
                    sel_d   = sel;
                    wdata_d = wdata;
                    if (WAIT_CYC > 0) begin
                        state_d = WAIT;
                        cnt_d   = WCNT_W'(WAIT_CYC - 1);
                    end else begin
                        access = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!dbus_cyc_o) begin
                    // Master abandoned the cycle: drop it silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (access) begin
            if (!in_range) begin
                err_d = 1'b1;
            end else begin
                done_d = 1'b1;
                if (!acc_wr) begin
                    rdata_d = ram_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Request registers are only meaningful while in WAIT, so they need no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wr_q    <= wr_d;
        sel_q   <= sel_d;
        wdata_q <= wdata_d;
    end

    dm_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (acc_sel),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign rdata = rdata_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dm_wb.sv
// tb/tb_dm_wb.sv - scoreboard bench for dm_wb (zero-wait/DEPTH=100 and 3-wait instances)
module tb_dm_wb;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  addr  [2];
    logic        wr    [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic [3:0]  sel   [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        done  [2];
    logic        err   [2];

    int          cyc_n   = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    dm_wb #(.DATA_W(32), .ADDR_W(7), .DEPTH(100), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr[0]), .wr(wr[0]),
        .dbus_cyc_o(cyc[0]), .dbus_stb_o(stb[0]), .sel(sel[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .done(done[0]), .err(err[0])
    );

    dm_wb #(.DATA_W(32), .ADDR_W(7), .DEPTH(128), .WAIT_CYC(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr[1]), .wr(wr[1]),
        .dbus_cyc_o(cyc[1]), .dbus_stb_o(stb[1]), .sel(sel[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .done(done[1]), .err(err[1])
    );

    function automatic int wc(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic is_err, input int c);
        exp_t e;
        e.is_err = is_err;
        e.data   = model_rd[d];
        e.cyc    = c;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   sz;
        if (done[d] || err[d]) begin
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp dut%0d: done=%0d err=%0d at cycle %0d, expected none",
                         d, done[d], err[d], cyc_n);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("resp_cycle_dut%0d", d), 32'(cyc_n), 32'(e.cyc));
                check($sformatf("resp_err_dut%0d", d), 32'(err[d]), 32'(e.is_err));
                check($sformatf("resp_done_dut%0d", d), 32'(done[d]), 32'(!e.is_err));
                check($sformatf("resp_rdata_dut%0d", d), rdata[d], e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Called at a negedge; returns at a negedge with the DUT idle and past turnaround.
    // After acceptance stb drops and the request inputs are scrambled while cyc stays high.
    task automatic xfer(input int d, input logic [6:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] wd, input logic is_err, input logic [31:0] rd_exp);
        addr[d] = a; wr[d] = w; sel[d] = s; wdata[d] = wd;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        if (!is_err && !w) model_rd[d] = rd_exp;
        push(d, is_err, cyc_n + 1 + wc(d));
        @(negedge clk);
        stb[d] = 1'b0; addr[d] = ~a; wdata[d] = ~wd; sel[d] = ~s; wr[d] = ~w;
        repeat (wc(d) + 1) @(negedge clk);
        cyc[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wr[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
            sel[d] = '0; wdata[d] = '0; model_rd[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_rdata_dut%0d", d), rdata[d], 32'h0);
            check($sformatf("reset_done_dut%0d", d), 32'(done[d]), 32'h0);
            check($sformatf("reset_err_dut%0d", d), 32'(err[d]), 32'h0);
        end
        rst_n = 1'b1;

        // Zero-wait instance, DEPTH=100
        xfer(0, 7'd5, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, '0);
        check("rdata_before_first_read", rdata[0], 32'h0);
        xfer(0, 7'd5, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF);
        xfer(0, 7'd3, 1'b1, 4'hF, 32'h11223344, 1'b0, '0);
        xfer(0, 7'd3, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, '0);
        xfer(0, 7'd3, 1'b0, 4'h0, 32'h0, 1'b0, 32'h11223344);
        xfer(0, 7'd3, 1'b1, 4'b1010, 32'hAABBCCDD, 1'b0, '0);
        xfer(0, 7'd3, 1'b0, 4'b0001, 32'h0, 1'b0, 32'hAA22CC44);
        xfer(0, 7'd99, 1'b1, 4'hF, 32'h99999999, 1'b0, '0);
        xfer(0, 7'd100, 1'b1, 4'hF, 32'h12121212, 1'b1, '0);
        xfer(0, 7'd127, 1'b0, 4'hF, 32'h0, 1'b1, '0);
        xfer(0, 7'd99, 0, 4'hF, 32'h0, 1'b0, 32'h99999999);

        // Three-wait instance
        xfer(1, 7'd0, 1'b1, 4'hF, 32'hA5A50000, 1'b0, '0);
        xfer(1, 7'd7, 1'b1, 4'hF, 32'hCAFE0007, 1'b0, '0);

        // Back-to-back reads with stb held: accepts at k+1 and k+6
        k = cyc_n;
        addr[1] = 7'd0; wr[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
        model_rd[1] = 32'hA5A50000;
        push(1, 1'b0, k + 4);
        push(1, 1'b0, k + 9);
        repeat (6) @(negedge clk);
        stb[1] = 1'b0;
        repeat (4) @(negedge clk);
        cyc[1] = 1'b0;

        // Abort: cyc drops in the first WAIT cycle
        addr[1] = 7'd7; wr[1] = 1'b1; sel[1] = 4'hF; wdata[1] = 32'h12345678;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (6) @(negedge clk);
        xfer(1, 7'd7, 1'b0, 4'hF, 32'h0, 1'b0, 32'hCAFE0007);

        // Reset in the middle of a WAIT write
        xfer(1, 7'd9, 1'b1, 4'hF, 32'h99990009, 1'b0, '0);
        xfer(1, 7'd9, 1'b0, 4'hF, 32'h0, 1'b0, 32'h99990009);
        addr[1] = 7'd9; wr[1] = 1'b1; sel[1] = 4'hF; wdata[1] = 32'h0BADBAD9;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_rdata_dut1", rdata[1], 32'h0);
        check("async_reset_rdata_dut0", rdata[0], 32'h0);
        check("async_reset_done_dut1", 32'(done[1]), 32'h0);
        check("async_reset_err_dut1", 32'(err[1]), 32'h0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 7'd9, 1'b0, 4'hF, 32'h0, 1'b0, 32'h99990009);
        xfer(0, 7'd5, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF);

        repeat (6) @(negedge clk);
        check("pending_dut0", 32'(q0.size()), 32'h0);
        check("pending_dut1", 32'(q1.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
